// File: rtl/coin_pkg.sv
// Shared map geometry, tile codes and FSM state encoding for the coin tracker.
package coin_pkg;

    localparam int MAP_W    = 48;
    localparam int MAP_H    = 27;
    localparam int COIN_CNT = MAP_W * MAP_H;
    localparam int ADDR_W   = 11;

    localparam logic [3:0] TILE_BG   = 4'd0;
    localparam logic [3:0] TILE_WALL = 4'd1;
    localparam logic [3:0] TILE_COIN = 4'd2;

    // Largest score the four BCD digits hold with the units digit pinned at 0.
    localparam logic [15:0] SCORE_MAX = 16'h9990;

    typedef enum logic [1:0] {
        INIT,
        RUN,
        CLEAR
    } state_t;

endpackage

// File: rtl/coin_tracker_bcd_add_sat.sv
// Adds a tens-digit increment to a BCD score (units digit implied 0),
// saturating at 9990 instead of wrapping.
module bcd_add_sat
    import coin_pkg::*;
(
    input  logic [11:0] digits,
    input  logic [3:0]  add_tens,
    output logic [15:0] sum
);

    logic [4:0] tens_raw;
    logic [4:0] hund_raw;
    logic [4:0] thou_raw;
    logic [3:0] tens_d;
    logic [3:0] hund_d;
    logic [3:0] thou_d;
    logic       carry_t;
    logic       carry_h;
    logic       carry_th;

    always_comb begin
        tens_raw = {1'b0, digits[3:0]} + {1'b0, add_tens};
        carry_t  = (tens_raw > 5'd9);
        tens_d   = carry_t ? 4'(tens_raw - 5'd10) : tens_raw[3:0];

        hund_raw = {1'b0, digits[7:4]} + {4'd0, carry_t};
        carry_h  = (hund_raw > 5'd9);
        hund_d   = carry_h ? 4'(hund_raw - 5'd10) : hund_raw[3:0];

        thou_raw = {1'b0, digits[11:8]} + {4'd0, carry_h};
        carry_th = (thou_raw > 5'd9);
        thou_d   = carry_th ? 4'(thou_raw - 5'd10) : thou_raw[3:0];

        // A carry out of the thousands digit means the true sum passed 9990.
        sum = carry_th ? SCORE_MAX : {thou_d, hund_d, tens_d, 4'h0};
    end

endmodule

// File: rtl/coin_tracker.sv
// Coin storage owner: loads coins from the tile ROM, clears eaten coins,
// answers renderer lookups, and tracks coins left, BCD score and level clear.
module coin_tracker
    import coin_pkg::*;
#(
    parameter int         MAP_W     = coin_pkg::MAP_W,
    parameter int         MAP_H     = coin_pkg::MAP_H,
    parameter int         COIN_CNT  = MAP_W * MAP_H,
    parameter int         ADDR_W    = coin_pkg::ADDR_W,
    parameter logic [3:0] COIN_CODE = TILE_COIN,
    parameter int         POINTS    = 10
) (
    input  logic              clk_pix,
    input  logic              reset,
    input  logic              start_init,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [3:0]        rom_code,
    input  logic              eat_valid,
    input  logic [ADDR_W-1:0] eat_addr,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_coin,
    output logic              coin_eaten,
    output logic [ADDR_W-1:0] coins_left,
    output logic [15:0]       score_bcd,
    output logic              all_clear,
    output logic              init_busy
);

    localparam logic [ADDR_W-1:0] ADDR_LIM  = ADDR_W'(COIN_CNT);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(COIN_CNT - 1);
    localparam logic [ADDR_W-1:0] ONE       = ADDR_W'(1);
    localparam logic [3:0]        ADD_TENS  = 4'(POINTS / 10);

    state_t state;
    state_t state_next;

    logic [COIN_CNT-1:0] coin_bits;

    // ROM read pipeline: load_addr/load_valid describe the tile whose code
    // is on rom_code this cycle.
    logic              issue_done;
    logic              load_valid;
    logic [ADDR_W-1:0] load_addr;

    logic              load_hit;
    logic              load_last;
    logic              eat_hit;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic              mem_wdata;
    logic [15:0]       score_sum;

    bcd_add_sat u_bcd (
        .digits   (score_bcd[15:4]),
        .add_tens (ADD_TENS),
        .sum      (score_sum)
    );

    assign init_busy = (state == INIT);
    assign all_clear = (state == CLEAR);

    // NOTE: every signal driven here gets a default first so no path through
    // the block leaves a value unassigned and infers a latch.
    always_comb begin
        load_hit   = (rom_code == COIN_CODE);
        load_last  = (state == INIT) && load_valid && (load_addr == LAST_ADDR);
        eat_hit    = (state == RUN) && eat_valid && !start_init &&
                     (eat_addr < ADDR_LIM) && coin_bits[eat_addr];

        mem_we     = ((state == INIT) && load_valid) || eat_hit;
        mem_waddr  = (state == INIT) ? load_addr : eat_addr;
        mem_wdata  = (state == INIT) && load_hit;

        state_next = state;
        unique case (state)
            INIT: begin
                // The final write may itself add the only coin of the map.
                if (load_last) begin
                    state_next = ((coins_left != '0) || load_hit) ? RUN : CLEAR;
                end
            end
            RUN: begin
                if (eat_hit && (coins_left == ONE)) begin
                    state_next = CLEAR;
                end
            end
            CLEAR: state_next = CLEAR;
            default: state_next = INIT;
        endcase

        if (start_init) begin
            state_next = INIT;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours, matching real flops.
    always_ff @(posedge clk_pix) begin
        if (reset) begin
            state      <= INIT;
            rom_addr   <= '0;
            issue_done <= 1'b0;
            load_valid <= 1'b0;
            load_addr  <= '0;
            coins_left <= '0;
            score_bcd  <= '0;
            coin_eaten <= 1'b0;
            rd_coin    <= 1'b0;
        end else begin
            state      <= state_next;
            coin_eaten <= eat_hit;
            rd_coin    <= (rd_addr < ADDR_LIM) && coin_bits[rd_addr];

            if (start_init) begin
                rom_addr   <= '0;
                issue_done <= 1'b0;
                load_valid <= 1'b0;
                coins_left <= '0;
            end else if (state == INIT) begin
                load_valid <= !issue_done;
                load_addr  <= rom_addr;
                if (!issue_done) begin
                    if (rom_addr == LAST_ADDR) begin
                        issue_done <= 1'b1;
                    end else begin
                        rom_addr <= rom_addr + ONE;
                    end
                end
                if (load_valid && load_hit) begin
                    coins_left <= coins_left + ONE;
                end
            end else if (eat_hit) begin
                coins_left <= coins_left - ONE;
                score_bcd  <= score_sum;
            end
        end
    end

    // NOTE: the coin array has no reset; INIT rewrites every bit, and leaving
    // it out of reset lets it map onto distributed RAM.
    always_ff @(posedge clk_pix) begin
        if (mem_we) begin
            coin_bits[mem_waddr] <= mem_wdata;
        end
    end

endmodule

// File: tb/tb_coin_tracker.sv
// Self-checking bench for coin_tracker: directed phases plus randomized eats,
// compared against a set-and-counter reference model of the coin rules.
module tb_coin_tracker;
    import coin_pkg::*;

    localparam int N      = COIN_CNT;
    localparam int POINTS = 10;

    logic        clk_pix    = 1'b0;
    logic        reset      = 1'b1;
    logic        start_init = 1'b0;
    logic        eat_valid  = 1'b0;
    logic [10:0] eat_addr   = '0;
    logic [10:0] rd_addr    = '0;
    logic [3:0]  rom_code   = 4'd0;
    logic [10:0] rom_addr;
    logic        rd_coin;
    logic        coin_eaten;
    logic [10:0] coins_left;
    logic [15:0] score_bcd;
    logic        all_clear;
    logic        init_busy;

    coin_tracker dut (
        .clk_pix    (clk_pix),
        .reset      (reset),
        .start_init (start_init),
        .rom_addr   (rom_addr),
        .rom_code   (rom_code),
        .eat_valid  (eat_valid),
        .eat_addr   (eat_addr),
        .rd_addr    (rd_addr),
        .rd_coin    (rd_coin),
        .coin_eaten (coin_eaten),
        .coins_left (coins_left),
        .score_bcd  (score_bcd),
        .all_clear  (all_clear),
        .init_busy  (init_busy)
    );

    always #5 clk_pix = ~clk_pix;

    // Tile-map ROM with one cycle of read latency.
    logic [3:0] rom_map [N];
    always @(posedge clk_pix) rom_code <= rom_map[rom_addr];

    bit model_coins [N];
    int model_left;
    int model_score;
    bit model_clear;
    int coin_q[$];
    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    task automatic step();
        @(posedge clk_pix);
        #1;
    endtask

    // mode 0: no coins, 1: coins at 0/47/1295, 2: random, 3: every tile a coin
    task automatic fill_rom(input int mode);
        logic [3:0] c;
        for (int a = 0; a < N; a++) begin
            c = 4'($urandom_range(0, 14));
            if (c >= TILE_COIN) c = c + 4'd1;
            if (mode == 2 && $urandom_range(0, 15) == 0) c = TILE_COIN;
            if (mode == 3) c = TILE_COIN;
            rom_map[a] = c;
        end
        if (mode == 1) begin
            rom_map[0]    = TILE_COIN;
            rom_map[47]   = TILE_COIN;
            rom_map[1295] = TILE_COIN;
        end
        if (mode == 2) begin
            rom_map[5]    = TILE_COIN;
            rom_map[500]  = TILE_COIN;
            rom_map[900]  = TILE_COIN;
            rom_map[1000] = TILE_COIN;
        end
    endtask

    task automatic model_init();
        coin_q.delete();
        model_left = 0;
        for (int a = 0; a < N; a++) begin
            model_coins[a] = (rom_map[a] == TILE_COIN);
            if (model_coins[a]) begin
                coin_q.push_back(a);
                model_left++;
            end
        end
        model_clear = (model_left == 0);
    endtask

    // Entered in cycle 0 of INIT; returns in the first cycle after INIT.
    task automatic run_init();
        check("init_c0_rom_addr", 32'(rom_addr), 32'd0);
        check("init_c0_busy", 32'(init_busy), 32'd1);
        check("init_c0_clear", 32'(all_clear), 32'd0);
        repeat (100) step();
        check("init_c100_rom_addr", 32'(rom_addr), 32'd100);
        repeat (1196) step();
        check("init_c1296_busy", 32'(init_busy), 32'd1);
        step();
        model_init();
        check("init_c1297_busy", 32'(init_busy), 32'd0);
        check("init_coins_left", 32'(coins_left), 32'(model_left));
        check("init_all_clear", 32'(all_clear), 32'(model_clear));
        check("init_score", 32'(score_bcd), 32'(to_bcd(model_score)));
    endtask

    task automatic pulse_start();
        eat_valid  = 1'b0;
        start_init = 1'b1;
        step();
        start_init = 1'b0;
    endtask

    // One RUN/CLEAR cycle: drive an eat and a lookup, then check all outputs.
    task automatic cyc(input bit ev, input int ea, input int ra);
        logic exp_rd;
        bit   hit;
        eat_valid = ev;
        eat_addr  = 11'(ea);
        rd_addr   = 11'(ra);
        exp_rd    = (ra < N) ? model_coins[ra] : 1'b0;
        hit       = ev && !model_clear && (ea < N) && model_coins[ea];
        step();
        if (hit) begin
            model_coins[ea] = 1'b0;
            model_left--;
            model_score = (model_score + POINTS > 9990) ? 9990 : model_score + POINTS;
            if (model_left == 0) model_clear = 1'b1;
        end
        check("coin_eaten", 32'(coin_eaten), 32'(hit));
        check("coins_left", 32'(coins_left), 32'(model_left));
        check("score_bcd", 32'(score_bcd), 32'(to_bcd(model_score)));
        check("all_clear", 32'(all_clear), 32'(model_clear));
        check("rd_coin", 32'(rd_coin), 32'(exp_rd));
    endtask

    task automatic sweep();
        for (int a = 0; a < N + 2; a++) cyc(1'b0, 0, a);
        cyc(1'b0, 0, 2047);
        cyc(1'b0, 0, 0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog timeout");
        $fatal(1, "simulation timeout");
    end

    initial begin
        int last_ea;
        int ea;
        int r;
        int a;

        model_score = 0;
        fill_rom(1);
        reset = 1'b1;
        step();
        step();
        check("rst_rom_addr", 32'(rom_addr), 32'd0);
        check("rst_rd_coin", 32'(rd_coin), 32'd0);
        check("rst_coin_eaten", 32'(coin_eaten), 32'd0);
        check("rst_coins_left", 32'(coins_left), 32'd0);
        check("rst_score", 32'(score_bcd), 32'd0);
        check("rst_all_clear", 32'(all_clear), 32'd0);
        check("rst_init_busy", 32'(init_busy), 32'd1);
        reset = 1'b0;
        run_init();
        check("three_coins", 32'(coins_left), 32'd3);
        sweep();

        // Same address three cycles running: one pulse; read after clear sees 0.
        cyc(1'b1, 47, 47);
        cyc(1'b1, 47, 47);
        cyc(1'b1, 47, 47);
        cyc(1'b0, 0, 47);
        check("score_after_47", 32'(score_bcd), 32'h0010);

        cyc(1'b1, 0, 0);
        cyc(1'b1, 1295, 1295);
        check("cleared", 32'(all_clear), 32'd1);
        cyc(1'b1, 0, 0);
        cyc(1'b0, 0, 0);

        // Random map: eat a few, then start_init colliding with an eat.
        fill_rom(2);
        pulse_start();
        run_init();
        for (int i = 0; i < 3; i++) cyc(1'b1, coin_q[i], coin_q[i]);
        ea         = coin_q[3];
        start_init = 1'b1;
        eat_valid  = 1'b1;
        eat_addr   = 11'(ea);
        step();
        start_init = 1'b0;
        eat_valid  = 1'b0;
        check("collide_no_eat", 32'(coin_eaten), 32'd0);
        check("collide_busy", 32'(init_busy), 32'd1);
        check("collide_score", 32'(score_bcd), 32'(to_bcd(model_score)));
        run_init();
        sweep();

        last_ea = 0;
        for (int i = 0; i < 400; i++) begin
            r = int'($urandom_range(0, 9));
            if (r < 5 && coin_q.size() > 0) ea = coin_q[$urandom_range(0, coin_q.size() - 1)];
            else if (r < 6) ea = N + int'($urandom_range(0, 2047 - N));
            else if (r < 7) ea = last_ea;
            else ea = int'($urandom_range(0, N - 1));
            cyc(r != 7, ea, int'($urandom_range(0, 2047)));
            last_ea = ea;
        end
        cyc(1'b0, 0, 0);

        // Map without coins goes straight to CLEAR; eats are ignored there.
        fill_rom(0);
        pulse_start();
        run_init();
        check("empty_clear", 32'(all_clear), 32'd1);
        cyc(1'b1, 100, 100);
        cyc(1'b0, 0, 0);

        // Every tile a coin: climb to 9980, then saturate at 9990.
        fill_rom(3);
        pulse_start();
        run_init();
        a = 0;
        while (model_score < 9980 && a < N) begin
            cyc(1'b1, a, a);
            a++;
        end
        check("score_9980", 32'(score_bcd), 32'h9980);
        cyc(1'b1, a, a);
        cyc(1'b1, a + 1, a + 1);
        cyc(1'b1, a + 2, a + 2);
        check("score_sat", 32'(score_bcd), 32'h9990);
        cyc(1'b0, 0, 0);

        // Reset in the middle of INIT restarts from address 0.
        pulse_start();
        repeat (500) step();
        check("mid_init_rom_addr", 32'(rom_addr), 32'd500);
        reset = 1'b1;
        step();
        model_score = 0;
        check("mid_rst_rom_addr", 32'(rom_addr), 32'd0);
        check("mid_rst_busy", 32'(init_busy), 32'd1);
        check("mid_rst_score", 32'(score_bcd), 32'd0);
        check("mid_rst_left", 32'(coins_left), 32'd0);
        reset = 1'b0;
        run_init();
        cyc(1'b1, 7, 7);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
